// File: rtl/mux_seq_pkg.sv
// Shared types and width helpers for the mux select sequencer.
// Holds the FSM state encoding and the select/divider width functions.
package mux_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } seq_state_t;

    // Select width: $clog2 of the word width, never below 1 bit.
    function automatic int sel_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

    // Divider counter width: max(1, $clog2(DIV)).
    function automatic int cnt_width(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/mux_4to1.sv
// 4:1 select mux: o_selected = i_data[i_sel], purely combinational.
// Ports: i_sel (2b select), i_data (4b inputs), o_selected (chosen bit).
module mux_4to1 (
    input  logic [1:0] i_sel,
    input  logic [3:0] i_data,
    output logic       o_selected
);

    always_comb begin
        o_selected = 1'b0;
        unique case (i_sel)
            2'd0:    o_selected = i_data[0];
            2'd1:    o_selected = i_data[1];
            2'd2:    o_selected = i_data[2];
            2'd3:    o_selected = i_data[3];
            default: o_selected = 1'b0;
        endcase
    end

endmodule

// File: rtl/mux_sel_sequencer.sv
// Parallel-to-serial front end: captures a word on valid/ready and walks
// the mux select over every bit, DIV cycles per bit, one bit on o_serial.
// Ports: i_clk, i_rst_n (async low), i_data/i_valid/o_ready (input word),
// o_sel, o_serial, o_serial_valid, o_last, o_busy (serial side).
// Optional macro MUX_SEQ_PARITY_EN appends an even-parity slot per word.
module mux_sel_sequencer
    import mux_seq_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int DIV       = 1,
    parameter bit LSB_FIRST = 1'b1,
    localparam int SW       = sel_width(WIDTH),
    localparam int CW       = cnt_width(DIV)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_valid,
    output logic             o_ready,
    output logic [SW-1:0]    o_sel,
    output logic             o_serial,
    output logic             o_serial_valid,
    output logic             o_last,
    output logic             o_busy
);

    localparam logic [SW-1:0] SEL_FIRST = LSB_FIRST ? SW'(0) : SW'(WIDTH - 1);
    localparam logic [SW-1:0] SEL_FINAL = LSB_FIRST ? SW'(WIDTH - 1) : SW'(0);
    localparam logic [CW-1:0] CNT_MAX   = CW'(DIV - 1);

    seq_state_t       state_q, state_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic [SW-1:0]    sel_q, sel_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic slot_end;
    logic on_final;
    logic word_end;
    logic accept;
    logic mux_bit;

    assign slot_end = (cnt_q == CNT_MAX);
    assign on_final = (state_q == SHIFT) && (sel_q == SEL_FINAL);

`ifdef MUX_SEQ_PARITY_EN
    assign word_end = (state_q == PARITY) && slot_end;
    assign o_last   = (state_q == PARITY);
    assign o_serial = (state_q == PARITY) ? ^hold_q
                    : ((state_q == SHIFT) & mux_bit);
`else
    assign word_end = on_final && slot_end;
    assign o_last   = on_final;
    assign o_serial = (state_q == SHIFT) & mux_bit;
`endif

    // Ready in IDLE, and for one cycle at word end so words stream
    // back-to-back without a bubble.
    assign o_ready        = (state_q == IDLE) || word_end;
    assign accept         = i_valid && o_ready;
    assign o_serial_valid = (state_q != IDLE);
    assign o_busy         = (state_q != IDLE);
    assign o_sel          = sel_q;

    generate
        if (WIDTH == 4) begin : g_mux4
            mux_4to1 u_mux (
                .i_sel      (sel_q),
                .i_data     (hold_q),
                .o_selected (mux_bit)
            );
        end else begin : g_muxn
            assign mux_bit = hold_q[sel_q];
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        if (accept) begin
            hold_d  = i_data;
            sel_d   = SEL_FIRST;
            cnt_d   = '0;
            state_d = SHIFT;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = IDLE;
                end
                SHIFT: begin
                    if (!slot_end) begin
                        cnt_d = cnt_q + 1'b1;
                    end else begin
                        cnt_d = '0;
                        if (sel_q == SEL_FINAL) begin
`ifdef MUX_SEQ_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = IDLE;
`endif
                        end else if (LSB_FIRST) begin
                            sel_d = sel_q + 1'b1;
                        end else begin
                            sel_d = sel_q - 1'b1;
                        end
                    end
                end
                PARITY: begin
                    if (!slot_end) begin
                        cnt_d = cnt_q + 1'b1;
                    end else begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            hold_q  <= '0;
            sel_q   <= SEL_FIRST;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// Directed bench for mux_sel_sequencer: three instances cover
// DIV=1/LSB-first, DIV=1/MSB-first and DIV=3/LSB-first.
module tb_mux_sel_sequencer;

`ifdef MUX_SEQ_PARITY_EN
    localparam int NSLOT = 5;
`else
    localparam int NSLOT = 4;
`endif

    logic       clk;
    logic       rst_n;
    logic [3:0] data     [3];
    logic       valid    [3];
    logic       ready    [3];
    logic [1:0] sel      [3];
    logic       serial   [3];
    logic       svalid   [3];
    logic       last     [3];
    logic       busy     [3];

    int tests;
    int fails;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mux_sel_sequencer #(.WIDTH(4), .DIV(1), .LSB_FIRST(1'b1)) u_d0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_data(data[0]), .i_valid(valid[0]),
        .o_ready(ready[0]), .o_sel(sel[0]), .o_serial(serial[0]),
        .o_serial_valid(svalid[0]), .o_last(last[0]), .o_busy(busy[0])
    );

    mux_sel_sequencer #(.WIDTH(4), .DIV(1), .LSB_FIRST(1'b0)) u_d1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_data(data[1]), .i_valid(valid[1]),
        .o_ready(ready[1]), .o_sel(sel[1]), .o_serial(serial[1]),
        .o_serial_valid(svalid[1]), .o_last(last[1]), .o_busy(busy[1])
    );

    mux_sel_sequencer #(.WIDTH(4), .DIV(3), .LSB_FIRST(1'b1)) u_d2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_data(data[2]), .i_valid(valid[2]),
        .o_ready(ready[2]), .o_sel(sel[2]), .o_serial(serial[2]),
        .o_serial_valid(svalid[2]), .o_last(last[2]), .o_busy(busy[2])
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input int d, input logic [1:0] exp_sel,
                            input bit check_sel);
        chk($sformatf("d%0d idle busy", d), 32'(busy[d]), 0);
        chk($sformatf("d%0d idle ready", d), 32'(ready[d]), 1);
        chk($sformatf("d%0d idle svalid", d), 32'(svalid[d]), 0);
        chk($sformatf("d%0d idle last", d), 32'(last[d]), 0);
        chk($sformatf("d%0d idle serial", d), 32'(serial[d]), 0);
        if (check_sel)
            chk($sformatf("d%0d idle sel", d), 32'(sel[d]), 32'(exp_sel));
    endtask

    // Called at posedge+1 right after the accepting edge; walks every
    // slot cycle and leaves time at posedge+1 after the word's last edge.
    task automatic check_word(input int d, input logic [3:0] w,
                              input int div, input bit lsb,
                              input bit nv, input logic [3:0] nw);
        valid[d] = nv;
        data[d]  = nw;
        for (int s = 0; s < NSLOT; s++) begin
            for (int c = 0; c < div; c++) begin
                bit   par;
                int   idx;
                logic eb;
                bit   fin;
                par = (s == 4);
                if (par) idx = lsb ? 3 : 0;
                else     idx = lsb ? s : 3 - s;
                eb  = par ? ^w : w[idx];
                fin = (s == NSLOT - 1);
                chk($sformatf("d%0d w%h s%0d c%0d sel", d, w, s, c),
                    32'(sel[d]), 32'(idx));
                chk($sformatf("d%0d w%h s%0d c%0d serial", d, w, s, c),
                    32'(serial[d]), 32'(eb));
                chk($sformatf("d%0d w%h s%0d c%0d svalid", d, w, s, c),
                    32'(svalid[d]), 1);
                chk($sformatf("d%0d w%h s%0d c%0d busy", d, w, s, c),
                    32'(busy[d]), 1);
                chk($sformatf("d%0d w%h s%0d c%0d last", d, w, s, c),
                    32'(last[d]), 32'(fin));
                chk($sformatf("d%0d w%h s%0d c%0d ready", d, w, s, c),
                    32'(ready[d]), 32'(fin && (c == div - 1)));
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic load(input int d, input logic [3:0] w);
        valid[d] = 1'b1;
        data[d]  = w;
        @(posedge clk); #1;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        for (int i = 0; i < 3; i++) begin
            valid[i] = 1'b0;
            data[i]  = 4'h0;
        end
        rst_n = 1'b0;
        #12;
        chk_idle(0, 2'd0, 1'b1);
        chk_idle(1, 2'd3, 1'b1);
        chk_idle(2, 2'd0, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Word 0110, DIV=1, LSB first, then return to IDLE.
        load(0, 4'b0110);
        check_word(0, 4'b0110, 1, 1'b1, 1'b0, 4'h0);
        chk_idle(0, 2'd0, 1'b0);

        // MSB first.
        load(1, 4'b0110);
        check_word(1, 4'b0110, 1, 1'b0, 1'b0, 4'h0);
        chk_idle(1, 2'd0, 1'b0);

        // DIV=3: each bit held three cycles.
        load(2, 4'b1001);
        check_word(2, 4'b1001, 3, 1'b1, 1'b0, 4'h0);
        chk_idle(2, 2'd0, 1'b0);

        // Back-to-back words with valid held through the first word.
        load(0, 4'b0110);
        check_word(0, 4'b0110, 1, 1'b1, 1'b1, 4'b1001);
        check_word(0, 4'b1001, 1, 1'b1, 1'b0, 4'h0);
        chk_idle(0, 2'd0, 1'b0);

        // Reset during bit 2 aborts the word at once.
        load(0, 4'b1011);
        valid[0] = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst pre sel", 32'(sel[0]), 2);
        chk("rst pre busy", 32'(busy[0]), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_idle(0, 2'd0, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        load(0, 4'b0101);
        check_word(0, 4'b0101, 1, 1'b1, 1'b0, 4'h0);
        chk_idle(0, 2'd0, 1'b0);

`ifdef MUX_SEQ_PARITY_EN
        load(0, 4'b0111);
        check_word(0, 4'b0111, 1, 1'b1, 1'b0, 4'h0);
        chk_idle(0, 2'd0, 1'b0);
        load(0, 4'b0110);
        check_word(0, 4'b0110, 1, 1'b1, 1'b0, 4'h0);
        chk_idle(0, 2'd0, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
